// File: rtl/irq_pkg.sv
// irq_pkg
// Shared definitions for the interrupt controller: the register map
// decoded on reg_addr, the STATUS bit layout, and the helper that
// resolves fixed priority across the active sources.
package irq_pkg;

  typedef enum logic [1:0] {
    REG_MASK    = 2'd0,
    REG_MODE    = 2'd1,
    REG_PENDING = 2'd2,
    REG_STATUS  = 2'd3
  } reg_addr_e;

  localparam int STATUS_NONE_BIT = 7;
  localparam int STATUS_NMI_BIT  = 6;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [2:0] find_first(input logic [7:0] vec);
    find_first = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) find_first = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync
// Multi-stage synchroniser for asynchronous inputs. Every stage resets
// to 1, which is the idle level of the active-low request lines, so
// leaving reset never looks like a falling edge.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   d            : asynchronous input bus
//   q            : synchronised output bus (STAGES cycles of latency)
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '1;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// irq_controller
// Prioritised interrupt controller with N_IRQ maskable sources (edge or
// level per source) and one edge-triggered NMI.
// Ports:
//   clk, reset_n          : clock and asynchronous active-low reset
//   irq_src_n, nmi_n      : asynchronous active-low requests
//   i_flag                : CPU interrupt-disable flag, 1 blocks IRQ
//   reg_we/addr/wdata     : register write port
//   reg_rdata             : combinational register read data
//   irq_ack, nmi_ack      : CPU entering IRQ / NMI sequence
//   take_irq, take_nmi    : registered requests to the CPU
//   irq_id                : registered index of highest-priority source
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_src_n,
  input  logic             nmi_n,
  input  logic             i_flag,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  input  logic             irq_ack,
  input  logic             nmi_ack,
  output logic             take_irq,
  output logic             take_nmi,
  output logic [2:0]       irq_id
);

  localparam logic [7:0] VALID = 8'((16'd1 << N_IRQ) - 16'd1);

  logic [N_IRQ:0] sync_q;
  logic [7:0]     src_low, src_low_q, fall;
  logic           nmi_low, nmi_low_q, nmi_fall, nmi_latch;
  logic [7:0]     mask_q, mode_q, latch_q;
  logic [7:0]     mask_d, mode_d, latch_d;
  logic [7:0]     pending, active, active_after;
  logic [7:0]     w1c, mode_clr, ack_clr, clr, set;
  logic           wr_mask, wr_mode, wr_pend;

  irq_sync #(.WIDTH(N_IRQ + 1), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({nmi_n, irq_src_n}),
    .q       (sync_q)
  );

  assign src_low  = 8'(~sync_q[N_IRQ-1:0]);
  assign nmi_low  = ~sync_q[N_IRQ];
  assign fall     = src_low & ~src_low_q;
  assign nmi_fall = nmi_low & ~nmi_low_q;

  assign wr_mask = reg_we && (reg_addr_e'(reg_addr) == REG_MASK);
  assign wr_mode = reg_we && (reg_addr_e'(reg_addr) == REG_MODE);
  assign wr_pend = reg_we && (reg_addr_e'(reg_addr) == REG_PENDING);

  assign mask_d = wr_mask ? (reg_wdata & VALID) : mask_q;
  assign mode_d = wr_mode ? (reg_wdata & VALID) : mode_q;

  assign pending = (latch_q & mode_q) | (src_low & ~mode_q);
  assign active  = pending & mask_q;

  // Clears only touch edge latches; a fresh edge is OR-ed in afterwards
  // so it always wins over a same-cycle clear.
  assign w1c      = wr_pend ? (reg_wdata & VALID) : 8'd0;
  assign mode_clr = mode_q & ~mode_d;
  assign ack_clr  = irq_ack ? ((8'd1 << irq_id) & active & mode_q) : 8'd0;
  assign clr      = w1c | mode_clr | ack_clr;
  assign set      = fall & mode_d & VALID;
  assign latch_d  = (latch_q & ~clr) | set;

  // Requests are computed from the post-clear view so an acknowledged
  // source drops take_irq on the very next edge, while new edges still
  // take their normal extra cycle through the latch.
  assign active_after = (((latch_q & ~clr) & mode_q) | (src_low & ~mode_q)) & mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_low_q <= 8'd0;
      nmi_low_q <= 1'b0;
      mask_q    <= 8'd0;
      mode_q    <= 8'd0;
      latch_q   <= 8'd0;
      nmi_latch <= 1'b0;
      take_irq  <= 1'b0;
      take_nmi  <= 1'b0;
      irq_id    <= 3'd0;
    end else begin
      src_low_q <= src_low;
      nmi_low_q <= nmi_low;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      latch_q   <= latch_d;
      nmi_latch <= nmi_fall | (nmi_latch & ~nmi_ack);
      take_irq  <= (|active_after) & ~i_flag;
      take_nmi  <= nmi_latch;
      irq_id    <= find_first(active_after);
    end
  end

  always_comb begin
    reg_rdata = 8'd0;
    case (reg_addr_e'(reg_addr))
      REG_MASK:    reg_rdata = mask_q;
      REG_MODE:    reg_rdata = mode_q;
      REG_PENDING: reg_rdata = pending & VALID;
      REG_STATUS: begin
        reg_rdata                  = 8'(irq_id);
        reg_rdata[STATUS_NONE_BIT] = ~|active;
        reg_rdata[STATUS_NMI_BIT]  = nmi_latch;
      end
      default:     reg_rdata = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Self-checking bench for irq_controller built with six sources so the
// unimplemented upper register bits can be exercised.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] irq_src_n;
  logic       nmi_n;
  logic       i_flag;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       irq_ack;
  logic       nmi_ack;
  logic       take_irq;
  logic       take_nmi;
  logic [2:0] irq_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    string      name;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(6), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_src_n (irq_src_n),
    .nmi_n     (nmi_n),
    .i_flag    (i_flag),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_ack   (irq_ack),
    .nmi_ack   (nmi_ack),
    .take_irq  (take_irq),
    .take_nmi  (take_nmi),
    .irq_id    (irq_id)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] addr, input logic [7:0] data);
    reg_we    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick(1);
    reg_we    = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [7:0] expected);
    reg_addr = addr;
    #1;
    check_output(name, reg_rdata, expected);
  endtask

  initial begin
    reset_n   = 1'b0;
    irq_src_n = '1;
    nmi_n     = 1'b1;
    i_flag    = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = 2'd0;
    reg_wdata = 8'd0;
    irq_ack   = 1'b0;
    nmi_ack   = 1'b0;

    vecs[0] = '{1'b0, 2'd0, 8'h00, 8'h00, "rst_mask"};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 8'h00, "rst_mode"};
    vecs[2] = '{1'b0, 2'd2, 8'h00, 8'h00, "rst_pending"};
    vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h80, "rst_status"};
    vecs[4] = '{1'b1, 2'd0, 8'hA5, 8'h25, "mask_upper_bits"};
    vecs[5] = '{1'b1, 2'd1, 8'hFF, 8'h3F, "mode_upper_bits"};
    vecs[6] = '{1'b1, 2'd1, 8'h00, 8'h00, "mode_clear"};
    vecs[7] = '{1'b1, 2'd0, 8'h00, 8'h00, "mask_clear"};
    vecs[8] = '{1'b1, 2'd3, 8'h55, 8'h80, "status_readonly"};
    vecs[9] = '{1'b1, 2'd2, 8'hFF, 8'h00, "pending_w1c_idle"};

    tick(3);
    check_output("rst_take_irq", 8'(take_irq), 8'h00);
    check_output("rst_take_nmi", 8'(take_nmi), 8'h00);
    check_output("rst_irq_id", 8'(irq_id), 8'h00);
    reset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) apply_stimulus(vecs[i].addr, vecs[i].wdata);
      read_check(vecs[i].name, vecs[i].addr, vecs[i].exp_rdata);
    end

    // Edge source 0: one-cycle pulse, four-cycle latency, ack drops it.
    apply_stimulus(2'd0, 8'h01);
    apply_stimulus(2'd1, 8'h01);
    irq_src_n[0] = 1'b0;
    tick(1);
    irq_src_n[0] = 1'b1;
    tick(2);
    check_output("edge_take_irq_early", 8'(take_irq), 8'h00);
    tick(1);
    check_output("edge_take_irq", 8'(take_irq), 8'h01);
    check_output("edge_irq_id", 8'(irq_id), 8'h00);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check_output("edge_ack_take_irq", 8'(take_irq), 8'h00);
    read_check("edge_ack_pending", 2'd2, 8'h00);

    // Level sources 3 and 5: lowest index wins.
    apply_stimulus(2'd0, 8'hFF);
    apply_stimulus(2'd1, 8'h00);
    irq_src_n[3] = 1'b0;
    irq_src_n[5] = 1'b0;
    tick(4);
    check_output("level_irq_id_3", 8'(irq_id), 8'h03);
    check_output("level_take_irq", 8'(take_irq), 8'h01);
    read_check("level_status_3", 2'd3, 8'h03);
    irq_src_n[3] = 1'b1;
    tick(4);
    check_output("level_irq_id_5", 8'(irq_id), 8'h05);
    read_check("level_status_5", 2'd3, 8'h05);

    // I flag blocks the request, clearing it lets it through next edge.
    i_flag = 1'b1;
    tick(2);
    check_output("iflag_block", 8'(take_irq), 8'h00);
    i_flag = 1'b0;
    tick(1);
    check_output("iflag_release", 8'(take_irq), 8'h01);
    irq_src_n[5] = 1'b1;
    tick(4);
    check_output("level_release_take_irq", 8'(take_irq), 8'h00);
    read_check("level_release_status", 2'd3, 8'h80);

    // PENDING write-1-to-clear racing a new source-2 edge.
    apply_stimulus(2'd0, 8'h00);
    apply_stimulus(2'd1, 8'h04);
    irq_src_n[2] = 1'b0;
    tick(1);
    irq_src_n[2] = 1'b1;
    tick(3);
    read_check("w1c_first_latch", 2'd2, 8'h04);
    irq_src_n[2] = 1'b0;
    tick(1);
    irq_src_n[2] = 1'b1;
    tick(1);
    apply_stimulus(2'd2, 8'h04);
    read_check("w1c_race_keeps", 2'd2, 8'h04);
    apply_stimulus(2'd2, 8'h04);
    read_check("w1c_plain_clears", 2'd2, 8'h00);

    // NMI edge coinciding with nmi_ack for the previous NMI.
    nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    tick(2);
    read_check("nmi_status_latched", 2'd3, 8'hC0);
    tick(1);
    check_output("nmi_take", 8'(take_nmi), 8'h01);
    nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    tick(1);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    read_check("nmi_race_status", 2'd3, 8'hC0);
    tick(1);
    check_output("nmi_race_take", 8'(take_nmi), 8'h01);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    read_check("nmi_ack_status", 2'd3, 8'h80);
    tick(1);
    check_output("nmi_ack_take", 8'(take_nmi), 8'h00);

    // Two edge sources: ack clears only the one named by irq_id.
    apply_stimulus(2'd1, 8'h12);
    apply_stimulus(2'd0, 8'h12);
    irq_src_n[1] = 1'b0;
    irq_src_n[4] = 1'b0;
    tick(1);
    irq_src_n[1] = 1'b1;
    irq_src_n[4] = 1'b1;
    tick(3);
    check_output("two_edge_id_1", 8'(irq_id), 8'h01);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check_output("two_edge_id_4", 8'(irq_id), 8'h04);
    check_output("two_edge_take", 8'(take_irq), 8'h01);
    read_check("two_edge_pending", 2'd2, 8'h10);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check_output("two_edge_done", 8'(take_irq), 8'h00);

    // Reset while source 1 is low and latched.
    irq_src_n[1] = 1'b0;
    tick(4);
    read_check("pre_reset_pending", 2'd2, 8'h02);
    check_output("pre_reset_id", 8'(irq_id), 8'h01);
    reset_n = 1'b0;
    #1;
    check_output("in_reset_take_irq", 8'(take_irq), 8'h00);
    check_output("in_reset_irq_id", 8'(irq_id), 8'h00);
    irq_src_n[1] = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(5);
    read_check("post_reset_pending", 2'd2, 8'h00);
    read_check("post_reset_mask", 2'd0, 8'h00);
    read_check("post_reset_status", 2'd3, 8'h80);
    check_output("post_reset_take_irq", 8'(take_irq), 8'h00);
    check_output("post_reset_take_nmi", 8'(take_nmi), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
